prog_counter: RTL

Programmable up/down counter: the parametrised successor to the basic load/enable wrap counter. It adds run-time direction, step size, lower and upper bounds, wrap, saturate and one-shot modes, and an enable prescaler. It is the timebase and event-count primitive for timers, PWM period generation and sample/frame counters. Channels that need several counters instantiate it once per channel.

---
 rtl/prog_counter.sv | 109 ++++++++++
 1 files changed

// File: rtl/prog_counter.sv
`default_nettype none
// ============================================================================
// Module   : prog_counter
// Brief    : Programmable up/down counter with bounds, wrap/saturate/one-shot
//            modes and an enable prescaler.
// Revision : 1.0
// ============================================================================
module prog_counter #(
  parameter int WIDTH   = 8,
  parameter int PRESC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_value,
  input  logic               en,
  input  logic               dir,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   step,
  input  logic [WIDTH-1:0]   min_value,
  input  logic [WIDTH-1:0]   max_value,
  input  logic [PRESC_W-1:0] presc,
  output logic [WIDTH-1:0]   count,
  output logic               tick,
  output logic               done,
  output logic               at_max,
  output logic               at_min
);

  localparam logic [1:0] c_mode_sat     = 2'b01;
  localparam logic [1:0] c_mode_oneshot = 2'b10;

  logic [WIDTH-1:0]   r_count;
  logic               r_tick;
  logic               r_done;
  logic [PRESC_W-1:0] r_pcnt;

  logic [WIDTH-1:0]   w_up_room;
  logic [WIDTH-1:0]   w_dn_room;
  logic               w_ovf;
  logic [WIDTH-1:0]   w_sat_bound;
  logic [WIDTH-1:0]   w_wrap_bound;
  logic [WIDTH-1:0]   w_stepped;

  // Headroom differences are plain WIDTH-bit unsigned; an out-of-range count
  // is caught by the >= / <= terms before the wrapped difference matters.
  always_comb begin
    w_up_room    = max_value - r_count;
    w_dn_room    = r_count - min_value;
    w_ovf        = dir ? ((r_count >= max_value) || (w_up_room < step))
                       : ((r_count <= min_value) || (w_dn_room < step));
    w_sat_bound  = dir ? max_value : min_value;
    w_wrap_bound = dir ? min_value : max_value;
    w_stepped    = dir ? (r_count + step) : (r_count - step);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_pcnt  <= '0;
    end else if (clr) begin
      r_count <= min_value;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_pcnt  <= '0;
    end else if (load) begin
      r_count <= load_value;
      r_tick  <= 1'b0;
      r_done  <= 1'b0;
      r_pcnt  <= '0;
    end else begin
      r_tick <= 1'b0;
      if (en) begin
        if (r_pcnt == presc) begin
          r_pcnt <= '0;
          // A finished one-shot freezes the count while the prescaler runs on.
          if (!(mode == c_mode_oneshot && r_done)) begin
            if (!w_ovf) begin
              r_count <= w_stepped;
            end else if (mode == c_mode_sat) begin
              r_count <= w_sat_bound;
              r_tick  <= (r_count != w_sat_bound);
            end else if (mode == c_mode_oneshot) begin
              r_count <= w_sat_bound;
              r_tick  <= 1'b1;
              r_done  <= 1'b1;
            end else begin
              r_count <= w_wrap_bound;
              r_tick  <= 1'b1;
            end
          end
        end else begin
          r_pcnt <= r_pcnt + 1'b1;
        end
      end
    end
  end

  assign count  = r_count;
  assign tick   = r_tick;
  assign done   = r_done;
  assign at_max = (r_count == max_value);
  assign at_min = (r_count == min_value);

endmodule
`default_nettype wire
